// File: rtl/axis_deadlock_pkg.sv
// rtl/axis_deadlock_pkg.sv - shared types and helpers for the AXIS deadlock watchdog
package axis_deadlock_pkg;

  typedef enum logic [1:0] {
    MONITOR  = 2'd0,
    COUNTING = 2'd1,
    TRIPPED  = 2'd2
  } wd_state_t;

  localparam int TRIP_CNT_W = 8;

  function automatic logic [TRIP_CNT_W-1:0] sat_inc(input logic [TRIP_CNT_W-1:0] v);
    return (&v) ? v : v + TRIP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/axis_deadlock_watchdog.sv
// rtl/axis_deadlock_watchdog.sv - persistence-filtered stall/deadlock watchdog
// Trips when a nonzero block vector holds steady for TIMEOUT cycles while the kernel is not idle.
module axis_deadlock_watchdog
  import axis_deadlock_pkg::*;
#(
  parameter  int NUM_AXIS = 4,
  parameter  int NUM_INST = 4,
  parameter  int TIMEOUT  = 1024,
  localparam int CNT_W    = $clog2(TIMEOUT + 1)
) (
  input  logic                  kernel_monitor_clock,
  input  logic                  kernel_monitor_reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [NUM_AXIS-1:0]   axis_block_sigs,
  input  logic [NUM_INST-1:0]   inst_idle_sigs,
  input  logic [NUM_INST-1:0]   inst_block_sigs,
  output logic                  block,
  output logic                  trip_pulse,
  output logic [NUM_AXIS-1:0]   block_chan,
  output logic [NUM_INST-1:0]   block_inst,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [TRIP_CNT_W-1:0] trip_count
);

  localparam int BV_W = NUM_AXIS + NUM_INST;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TIMEOUT);

  wd_state_t             r_state;
  logic [BV_W-1:0]       r_prev_bv;
  logic                  r_block;
  logic                  r_trip_pulse;
  logic [NUM_AXIS-1:0]   r_block_chan;
  logic [NUM_INST-1:0]   r_block_inst;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [TRIP_CNT_W-1:0] r_trip_count;

  logic [BV_W-1:0] w_bv;
  logic            w_stall;

  assign w_bv = {inst_block_sigs, axis_block_sigs};
  // All instances idle means the kernel finished, so a frozen vector is not a deadlock.
  assign w_stall = enable && (w_bv != '0) && (w_bv == r_prev_bv) && !(&inst_idle_sigs);

  always_ff @(posedge kernel_monitor_clock) begin
    if (kernel_monitor_reset) begin
      r_state      <= MONITOR;
      r_prev_bv    <= '0;
      r_block      <= 1'b0;
      r_trip_pulse <= 1'b0;
      r_block_chan <= '0;
      r_block_inst <= '0;
      r_stall_cnt  <= '0;
      r_trip_count <= '0;
    end else begin
      r_prev_bv    <= w_bv;
      r_trip_pulse <= 1'b0;
      if (clear) begin
        r_state      <= MONITOR;
        r_stall_cnt  <= '0;
        r_block      <= 1'b0;
        r_block_chan <= '0;
        r_block_inst <= '0;
      end else begin
        case (r_state)
          MONITOR: begin
            if (w_stall) begin
              r_state     <= COUNTING;
              r_stall_cnt <= CNT_W'(1);
            end
          end
          COUNTING: begin
            if (!w_stall) begin
              r_state     <= MONITOR;
              r_stall_cnt <= '0;
            end else if (r_stall_cnt == CNT_LAST) begin
              r_state      <= TRIPPED;
              r_stall_cnt  <= CNT_FULL;
              r_block      <= 1'b1;
              r_trip_pulse <= 1'b1;
              r_block_chan <= axis_block_sigs;
              r_block_inst <= inst_block_sigs;
              r_trip_count <= sat_inc(r_trip_count);
            end else begin
              r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
          end
          TRIPPED: r_state <= TRIPPED;
          default: begin
            r_state     <= MONITOR;
            r_stall_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign block      = r_block;
  assign trip_pulse = r_trip_pulse;
  assign block_chan = r_block_chan;
  assign block_inst = r_block_inst;
  assign stall_cnt  = r_stall_cnt;
  assign trip_count = r_trip_count;

endmodule
